// File: rtl/booth_radix4.sv
// Radix-4 Booth sequential multiplier.
// One Booth digit is retired per clock; signed or unsigned operands are
// chosen per operation and held for the whole operation.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// CALC  | retiring one radix-4 digit per cycle until the counter is empty
// DONE  | product presented with out_valid, held until out_ready
module booth_radix4 #(
   parameter int WIDTH  = 8,
   parameter int N_ITER = WIDTH / 2 + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   // Operands are widened by two bits so that unsigned values keep a zero
   // sign bit and the last Booth digit sees a proper sign; the adder gets one
   // more bit on top so that 2M plus the running sum can never overflow.
   localparam int EW = WIDTH + 2;
   localparam int AW = WIDTH + 3;
   localparam int CW = $clog2(N_ITER + 1);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_radix4: WIDTH must be even and at least 4");
   end
   if (N_ITER != WIDTH / 2 + 1) begin : g_bad_iter
      $error("booth_radix4: N_ITER is derived from WIDTH and must not be overridden");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state;
   logic [EW-1:0]        m_reg;
   logic [AW-1:0]        acc;
   logic [EW-1:0]        q_reg;
   logic                 q_m1;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   product_reg;

   logic [AW-1:0]        m_1x;
   logic [AW-1:0]        m_2x;
   logic [AW-1:0]        sel;
   logic                 neg;
   logic [AW-1:0]        addend;
   logic [AW-1:0]        sum;
   logic                 ext_m;
   logic                 ext_q;

   assign ext_m = is_signed & multiplicand[WIDTH-1];
   assign ext_q = is_signed & multiplier[WIDTH-1];

   // Booth digit decode and the single shared adder; subtraction reuses the
   // adder through an inverted addend and a carry-in of one.
   always_comb begin
      m_1x = {m_reg[EW-1], m_reg};
      m_2x = {m_reg, 1'b0};
      sel  = '0;
      neg  = 1'b0;
      unique case ({q_reg[1:0], q_m1})
         3'b001, 3'b010: sel = m_1x;
         3'b011:         sel = m_2x;
         3'b100: begin
            sel = m_2x;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            sel = m_1x;
            neg = 1'b1;
         end
         default: sel = '0;
      endcase
      addend = neg ? ~sel : sel;
      sum    = acc + addend + {{(AW-1){1'b0}}, neg};
   end

   // Control FSM together with the accumulator:Q shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         m_reg       <= '0;
         acc         <= '0;
         q_reg       <= '0;
         q_m1        <= 1'b0;
         cnt         <= '0;
         product_reg <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  m_reg <= {{2{ext_m}}, multiplicand};
                  q_reg <= {{2{ext_q}}, multiplier};
                  acc   <= '0;
                  q_m1  <= 1'b0;
                  cnt   <= CW'(N_ITER);
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               if (cnt != '0) begin
                  acc   <= {{2{sum[AW-1]}}, sum[AW-1:2]};
                  q_reg <= {sum[1:0], q_reg[EW-1:2]};
                  q_m1  <= q_reg[1];
                  cnt   <= cnt - 1'b1;
               end else begin
                  // Low 2*WIDTH bits of acc:Q; Q supplies WIDTH+2 of them.
                  product_reg <= {acc[WIDTH-3:0], q_reg};
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // in_ready is held low for as long as reset is applied.
   assign in_ready  = (state == S_IDLE) && !rst;
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign product   = product_reg;

endmodule

// File: tb/tb_booth_radix4.sv
// Scoreboard bench for booth_radix4 (WIDTH=8): a driver pushes the
// arithmetically computed product on every accept, a monitor compares on
// every cycle the DUT presents out_valid.
module tb_booth_radix4;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic            is_signed;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  product;
   logic            busy;

   logic            rand_bp = 1'b0;
   logic            rnd_rdy = 1'b1;
   logic            or_manual = 1'b1;

   typedef struct {
      logic [2*W-1:0] prod;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic prev_valid = 1'b0;

   booth_radix4 #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .is_signed    (is_signed),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) rnd_rdy = (($urandom % 4) != 0);

   assign out_ready = rand_bp ? rnd_rdy : or_manual;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                                              input logic s);
      longint a;
      longint b;
      logic [63:0] p;
      a = s ? longint'($signed(m)) : longint'({56'd0, m});
      b = s ? longint'($signed(q)) : longint'({56'd0, q});
      p = a * b;
      return p[2*W-1:0];
   endfunction

   // Monitor: compare whatever the DUT presents against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               if (!prev_valid)
                  chk("latency", cyc - sb[0].cyc, 32'd6);
               chk("product", {16'd0, product}, {16'd0, sb[0].prod});
               if (out_ready)
                  void'(sb.pop_front());
            end
         end
         prev_valid = out_valid;
      end
   end

   task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      multiplicand = m;
      multiplier   = q;
      is_signed    = s;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{ref_mul(m, q, s), cyc});
      in_valid     = 1'b0;
      // Scramble the ports: the operation must use only what was captured.
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      is_signed    = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [W-1:0] m;
      logic [W-1:0] q;
      logic         s;

      rst = 1'b1;
      in_valid = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      is_signed = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_product", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed corner cases.
      do_op(8'h80, 8'h80, 1'b1);
      do_op(8'hFF, 8'hFF, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1);
      do_op(8'hFF, 8'h01, 1'b1);
      do_op(8'h07, 8'hFD, 1'b1);
      do_op(8'h00, 8'h80, 1'b1);
      do_op(8'h7F, 8'h80, 1'b1);
      drain();

      // Backpressure: result must sit still while out_ready is low.
      or_manual = 1'b0;
      do_op(8'h80, 8'h80, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("bp_wait_valid", {31'd0, out_valid}, 32'd1);
      repeat (10) begin
         @(negedge clk);
         #1;
         chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
         chk("bp_product_hold", {16'd0, product}, 32'h4000);
         chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      or_manual = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Busy guard: a second in_valid pulse during CALC must be ignored.
      do_op(8'h05, 8'h03, 1'b0);
      @(negedge clk);
      @(negedge clk);
      multiplicand = 8'h11;
      multiplier   = 8'h11;
      in_valid     = 1'b1;
      #1;
      chk("guard_busy", {31'd0, busy}, 32'd1);
      chk("guard_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
      repeat (12) @(negedge clk);
      #1;
      chk("guard_no_second", {31'd0, out_valid}, 32'd0);
      chk("guard_idle", {31'd0, in_ready}, 32'd1);

      // Reset in the third CALC cycle aborts the operation.
      do_op(8'h5A, 8'h33, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_product", {16'd0, product}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_release_ready", {31'd0, in_ready}, 32'd1);
      do_op(8'h0C, 8'h0A, 1'b0);
      drain();
      repeat (10) @(negedge clk);

      // Randomized operands, modes and consumer backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 150; i++) begin
         m = W'($urandom);
         q = W'($urandom);
         s = 1'($urandom);
         if (i % 13 == 0) m = 8'h80;
         if (i % 17 == 0) q = 8'h80;
         if (i % 19 == 0) m = 8'hFF;
         do_op(m, q, s);
      end
      drain();
      rand_bp = 1'b0;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
